param_sp_ram: RTL and testbench

PARAM_SP_RAM -- requirements
Module: param_sp_ram

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_clear_fsm.sv | 66 ++++++
 rtl/param_sp_ram.sv | 172 +++++++++++++++++
 tb/tb_param_sp_ram.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parameterised single-port RAM: write-mode
// encodings and the state type of the power-on clear sequencer.
package ram_pkg;

    // Write-mode encodings for the WR_MODE parameter
    localparam int WR_NO_CHANGE   = 0;
    localparam int WR_READ_FIRST  = 1;
    localparam int WR_WRITE_FIRST = 2;

    // Clear sequencer states: CLEAR sweeps zeros through the array, READY serves accesses
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // True when a WR_MODE value names one of the supported behaviours
    function automatic logic wr_mode_legal(input int mode);
        return (mode == WR_NO_CHANGE) || (mode == WR_READ_FIRST) || (mode == WR_WRITE_FIRST);
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: after reset it walks a pointer from 0 to DEPTH-1, asking
// the array to zero one word per cycle, then parks in READY. The pointer
// stops at the last word rather than wrapping.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam clr_state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    clr_state_e              r_state;
    clr_state_e              w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic                    w_we;

    // State and pointer registers; reset restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= RST_STATE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state and pointer advance; the last word hands over to READY
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = READY;
                end else begin
                    w_ptr_nxt = r_ptr + PTR_ONE;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = w_we;
    assign clr_addr = r_ptr;

endmodule

// File: rtl/param_sp_ram.sv
// Parameterised single-port RAM with byte enables, 1- or 2-cycle registered
// read data, selectable write-return behaviour and an optional zeroing sweep
// after reset during which all accesses are ignored.
module param_sp_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int RD_LATENCY     = 1,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    wr_rd,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    out_en,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Reject unsupported configurations at elaboration time
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_dw
        $error("param_sp_ram: DATA_WIDTH must be a positive multiple of 8");
    end
    if (ADDR_WIDTH < 1) begin : g_bad_aw
        $error("param_sp_ram: ADDR_WIDTH must be at least 1");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_lat
        $error("param_sp_ram: RD_LATENCY must be 1 or 2");
    end
    if (!wr_mode_legal(WR_MODE)) begin : g_bad_mode
        $error("param_sp_ram: WR_MODE must be 0, 1 or 2");
    end
    if ((CLEAR_ON_RESET != 0) && (CLEAR_ON_RESET != 1)) begin : g_bad_clr
        $error("param_sp_ram: CLEAR_ON_RESET must be 0 or 1");
    end

    // Replace the bytes selected by byte_en with the matching bytes of new_word
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         byte_en
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic                    w_busy;
    logic                    w_clr_we;
    logic [ADDR_WIDTH-1:0]   w_clr_addr;
    logic                    w_acc;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_issue;
    logic [DATA_WIDTH-1:0]   w_issue_data;
    logic                    w_stage_vld;
    logic [DATA_WIDTH-1:0]   w_stage_data;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_out_en;

    ram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk      (clk),
        .rstn     (rstn),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_acc    = en & ~w_busy & rstn;
    assign w_old    = r_mem[addr];
    assign w_merged = merge_bytes(w_old, data_in, be);

    // Decide whether this access produces a result and which word it returns
    always_comb begin
        w_issue      = 1'b0;
        w_issue_data = w_old;
        if (w_acc) begin
            if (wr_rd) begin
                case (WR_MODE)
                    WR_READ_FIRST: begin
                        w_issue      = 1'b1;
                        w_issue_data = w_old;
                    end
                    WR_WRITE_FIRST: begin
                        w_issue      = 1'b1;
                        w_issue_data = w_merged;
                    end
                    default: begin
                        w_issue      = 1'b0;
                        w_issue_data = w_old;
                    end
                endcase
            end else begin
                w_issue      = 1'b1;
                w_issue_data = w_old;
            end
        end else begin
            w_issue      = 1'b0;
            w_issue_data = w_old;
        end
    end

    // Array update: the sweep owns the array while busy, user writes otherwise
    always_ff @(posedge clk) begin
        if (w_clr_we && rstn) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_acc && wr_rd) begin
            r_mem[addr] <= w_merged;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_p1_vld;
        logic [DATA_WIDTH-1:0] r_p1_data;

        // Extra pipeline stage; flushed by reset so no stale result escapes
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_p1_vld  <= 1'b0;
                r_p1_data <= '0;
            end else begin
                r_p1_vld  <= w_issue;
                r_p1_data <= w_issue_data;
            end
        end

        assign w_stage_vld  = r_p1_vld;
        assign w_stage_data = r_p1_data;
    end else begin : g_lat1
        assign w_stage_vld  = w_issue;
        assign w_stage_data = w_issue_data;
    end

    // Output register: strobe for one cycle, hold data between results
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_en   <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_out_en <= w_stage_vld;
            if (w_stage_vld) begin
                r_data_out <= w_stage_data;
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

    assign data_out = r_data_out;
    assign out_en   = r_out_en;
    assign busy     = w_busy;

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: three instances (one per write mode) share the
// same stimulus and are compared every cycle against a behavioural model
// built from a word array, a busy countdown and a due-cycle result table.
module tb_param_sp_ram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 16;
    localparam int NE    = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              en;
    logic              wr_rd;
    logic [AW-1:0]     addr;
    logic [NB-1:0]     be;
    logic [DW-1:0]     data_in;
    logic [2:0][DW-1:0] dout;
    logic [2:0]        oen;
    logic [2:0]        bsy;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        param_sp_ram #(
            .DATA_WIDTH     (DW),
            .ADDR_WIDTH     (AW),
            .RD_LATENCY     (2),
            .WR_MODE        (m),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .en       (en),
            .wr_rd    (wr_rd),
            .addr     (addr),
            .be       (be),
            .data_in  (data_in),
            .data_out (dout[m]),
            .out_en   (oen[m]),
            .busy     (bsy[m])
        );
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_m [DEPTH];
    int          busy_left = DEPTH;
    int          edge_n    = 0;
    bit          pend_v [3][NE];
    logic [31:0] pend_d [3][NE];
    bit          exp_v  [3];
    logic [31:0] exp_d  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // One clock: advance the model with the pre-edge inputs, then compare all outputs
    task automatic step();
        bit          s_rstn = rstn;
        bit          s_en   = en;
        bit          s_wr   = wr_rd;
        int          s_a    = int'(addr);
        logic [3:0]  s_be   = be;
        logic [31:0] s_d    = data_in;
        logic [31:0] old_w;
        logic [31:0] new_w;
        @(posedge clk);
        #1;
        edge_n++;
        if (!s_rstn) begin
            for (int m = 0; m < 3; m++) begin
                exp_v[m] = 1'b0;
                exp_d[m] = 32'h0;
            end
            busy_left = DEPTH;
        end else begin
            for (int m = 0; m < 3; m++) begin
                exp_v[m] = pend_v[m][edge_n];
                if (exp_v[m]) exp_d[m] = pend_d[m][edge_n];
            end
            if (busy_left > 0) begin
                mem_m[DEPTH - busy_left] = 32'h0;
                busy_left--;
            end else if (s_en) begin
                old_w = mem_m[s_a];
                if (s_wr) begin
                    new_w = merge(old_w, s_d, s_be);
                    mem_m[s_a] = new_w;
                    pend_v[1][edge_n + 1] = 1'b1; pend_d[1][edge_n + 1] = old_w;
                    pend_v[2][edge_n + 1] = 1'b1; pend_d[2][edge_n + 1] = new_w;
                end else begin
                    for (int m = 0; m < 3; m++) begin
                        pend_v[m][edge_n + 1] = 1'b1;
                        pend_d[m][edge_n + 1] = old_w;
                    end
                end
            end
        end
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("out_en[mode%0d]@%0d", m, edge_n), 32'(oen[m]), 32'(exp_v[m]));
            chk($sformatf("data_out[mode%0d]@%0d", m, edge_n), dout[m], exp_d[m]);
        end
        chk($sformatf("busy@%0d", edge_n), 32'(bsy[0]), 32'(busy_left > 0));
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] b);
        en = 1'b1; wr_rd = 1'b1; addr = AW'(a); data_in = d; be = b;
        step();
    endtask

    task automatic do_read(input int a);
        en = 1'b1; wr_rd = 1'b0; addr = AW'(a); be = 4'h0; data_in = $urandom;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b0; wr_rd = $urandom_range(0, 1); addr = AW'($urandom); data_in = $urandom;
            step();
        end
    endtask

    // Release reset and measure how long busy stays high, bounded at 40 cycles
    task automatic release_and_count(input string tag);
        int n;
        rstn = 1'b1;
        n = 0;
        while (bsy[0] && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            for (int e = 0; e < NE; e++) begin
                pend_v[m][e] = 1'b0;
                pend_d[m][e] = 32'h0;
            end
        end
        rstn = 1'b0; en = 1'b1; wr_rd = 1'b0; addr = '0; be = '0; data_in = '0;

        // Power-on sweep with en held high, then everything reads as zero
        step(); step();
        chk("reset_busy", 32'(bsy[0]), 32'd1);
        chk("reset_out_en", 32'(oen[0]), 32'd0);
        chk("reset_data", dout[0], 32'h0);
        en = 1'b1;
        release_and_count("sweep_len_first");
        for (int a = 0; a < DEPTH; a++) do_read(a);
        idle(2);

        // Byte-enable merge
        do_write(3, 32'hDEADBEEF, 4'hF);
        do_write(3, 32'h11223344, 4'b0101);
        do_read(3);
        idle(1);
        chk("merge_out_en", 32'(oen[0]), 32'd1);
        chk("merge_data", dout[0], 32'hDE22BE44);
        do_write(3, 32'hFFFFFFFF, 4'h0);
        do_read(3);
        idle(1);
        chk("be_zero_data", dout[0], 32'hDE22BE44);

        // Back-to-back reads return in order
        do_write(0, 32'hA0, 4'hF);
        do_write(1, 32'hA1, 4'hF);
        do_write(2, 32'hA2, 4'hF);
        do_read(0);
        do_read(1);
        chk("b2b_0", dout[0], 32'hA0);
        do_read(2);
        chk("b2b_1", dout[0], 32'hA1);
        idle(1);
        chk("b2b_2", dout[0], 32'hA2);
        idle(3);
        chk("hold_data", dout[0], 32'hA2);

        // Write-return behaviour of the three modes
        do_write(5, 32'h5, 4'hF);
        idle(2);
        do_write(5, 32'h9, 4'hF);
        idle(1);
        chk("rf_data", dout[1], 32'h5);
        chk("wf_data", dout[2], 32'h9);
        chk("nc_no_strobe", 32'(oen[0]), 32'd0);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rstn    = ($urandom_range(0, 99) != 0);
            en      = ($urandom_range(0, 3) != 0);
            wr_rd   = $urandom_range(0, 1);
            addr    = AW'($urandom);
            be      = NB'($urandom);
            data_in = $urandom;
            step();
        end
        rstn = 1'b0;
        step();
        release_and_count("sweep_len_random");

        // Reset mid-sweep at pointer 7 restarts the sweep
        for (int a = 0; a < DEPTH; a++) do_write(a, $urandom | 32'h1, 4'hF);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        idle(7);
        rstn = 1'b0;
        idle(1);
        release_and_count("sweep_len_restart");
        for (int a = 0; a < DEPTH; a++) do_read(a);
        idle(2);

        // Reset one cycle after a read discards the result
        do_write(4, 32'h44444444, 4'hF);
        do_read(4);
        rstn = 1'b0;
        idle(1);
        chk("flush_out_en", 32'(oen[0]), 32'd0);
        rstn = 1'b1;
        idle(2);
        chk("flush_no_late", 32'(oen[0]), 32'd0);

        // Accesses while busy are ignored
        idle(10);
        do_write(2, 32'h12345678, 4'hF);
        do_read(2);
        idle(1);
        chk("busy_no_strobe", 32'(oen[0]), 32'd0);
        for (int i = 0; i < 40 && bsy[0]; i++) idle(1);
        chk("busy_done", 32'(bsy[0]), 32'd0);
        do_read(2);
        idle(1);
        chk("busy_write_dropped", dout[0], 32'h0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
